// File: rtl/uart_pkg.sv
// Shared state encoding and oversampling constants for uart_core and its baud generator.
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks, shared by RX and TX.
module uart_baud_gen #(
    parameter int CLK_DIV = 163
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (tick)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end
endmodule

// File: rtl/uart_core.sv
// Full-duplex 16x-oversampled UART with shared baud tick.
// Optional even parity bit is enabled by defining UART_PARITY_EN.
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = 16,
    parameter int CLK_DIV    = 163
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_rx_err
);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int STOP_W = $clog2(STOP_TICKS + 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_TICKS - 1);
    localparam logic [3:0]        LAST_SMP  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]        MID_SMP   = 4'(MID_SAMPLE);

    logic tick;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (i_clk),
        .reset (i_reset),
        .tick  (tick)
    );

    logic rx_meta, rx_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    uart_state_t          rx_state;
    logic [3:0]           rx_sample;
    logic [BIT_W-1:0]     rx_bit;
    logic [STOP_W-1:0]    rx_stop;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_err;

`ifndef UART_PARITY_EN
    assign rx_par_err = 1'b0;
`endif

    // Sample counter is 4 bits, so in DATA/PARITY it wraps 15 -> 0 on its own.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_state   <= ST_IDLE;
            rx_sample  <= '0;
            rx_bit     <= '0;
            rx_stop    <= '0;
            rx_shift   <= '0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_rx_err   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_err <= 1'b0;
`endif
        end else begin
            o_rx_valid <= 1'b0;
            o_rx_err   <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        rx_state  <= ST_START;
                        rx_sample <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_sample == MID_SMP) begin
                            rx_sample <= '0;
                            rx_bit    <= '0;
                            rx_state  <= rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            rx_sample <= rx_sample + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        rx_sample <= rx_sample + 4'd1;
                        if (rx_sample == LAST_SMP) begin
                            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                            if (rx_bit == LAST_BIT) begin
                                rx_stop <= '0;
`ifdef UART_PARITY_EN
                                rx_state <= ST_PARITY;
`else
                                rx_state <= ST_STOP;
`endif
                            end else begin
                                rx_bit <= rx_bit + BIT_W'(1);
                            end
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        rx_sample <= rx_sample + 4'd1;
                        if (rx_sample == LAST_SMP) begin
                            rx_par_err <= rx_sync ^ (^rx_shift);
                            rx_stop    <= '0;
                            rx_state   <= ST_STOP;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (rx_stop == LAST_STOP) begin
                            rx_state <= ST_IDLE;
                            if (rx_sync && !rx_par_err) begin
                                o_rx_data  <= rx_shift;
                                o_rx_valid <= 1'b1;
                            end else begin
                                o_rx_err <= 1'b1;
                            end
                        end else begin
                            rx_stop <= rx_stop + STOP_W'(1);
                        end
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    uart_state_t          tx_state;
    logic [3:0]           tx_sample;
    logic [BIT_W-1:0]     tx_bit;
    logic [STOP_W-1:0]    tx_stop;
    logic [DATA_BITS-1:0] tx_shift;
`ifdef UART_PARITY_EN
    logic                 tx_parity;
`endif

    // o_tx is registered and always holds the level of the bit currently on the wire.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state  <= ST_IDLE;
            tx_sample <= '0;
            tx_bit    <= '0;
            tx_stop   <= '0;
            tx_shift  <= '0;
            o_tx      <= 1'b1;
            o_tx_busy <= 1'b0;
            o_tx_done <= 1'b0;
`ifdef UART_PARITY_EN
            tx_parity <= 1'b0;
`endif
        end else begin
            o_tx_done <= 1'b0;
            case (tx_state)
                ST_IDLE: begin
                    o_tx <= 1'b1;
                    if (i_tx_start && !o_tx_busy) begin
                        tx_shift  <= i_tx_data;
`ifdef UART_PARITY_EN
                        tx_parity <= ^i_tx_data;
`endif
                        tx_sample <= '0;
                        o_tx      <= 1'b0;
                        o_tx_busy <= 1'b1;
                        tx_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_sample <= tx_sample + 4'd1;
                        if (tx_sample == LAST_SMP) begin
                            tx_bit   <= '0;
                            o_tx     <= tx_shift[0];
                            tx_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        tx_sample <= tx_sample + 4'd1;
                        if (tx_sample == LAST_SMP) begin
                            if (tx_bit == LAST_BIT) begin
                                tx_stop <= '0;
`ifdef UART_PARITY_EN
                                o_tx     <= tx_parity;
                                tx_state <= ST_PARITY;
`else
                                o_tx     <= 1'b1;
                                tx_state <= ST_STOP;
`endif
                            end else begin
                                tx_bit   <= tx_bit + BIT_W'(1);
                                tx_shift <= tx_shift >> 1;
                                o_tx     <= tx_shift[1];
                            end
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        tx_sample <= tx_sample + 4'd1;
                        if (tx_sample == LAST_SMP) begin
                            tx_stop  <= '0;
                            o_tx     <= 1'b1;
                            tx_state <= ST_STOP;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (tx_stop == LAST_STOP) begin
                            o_tx_done <= 1'b1;
                            o_tx_busy <= 1'b0;
                            tx_state  <= ST_IDLE;
                        end else begin
                            tx_stop <= tx_stop + STOP_W'(1);
                        end
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core (CLK_DIV=4, 64 clocks per bit).
module tb_uart_core;
    localparam int DATA_BITS = 8;
    localparam int STOP_TICKS = 16;
    localparam int CLK_DIV = 4;
    localparam int BIT_CYC = 64;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + DATA_BITS + P + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    logic tx_start = 1'b0;
    logic [DATA_BITS-1:0] tx_data = '0;
    logic rx_line;
    logic tx, tx_busy, tx_done, rx_valid, rx_err;
    logic [DATA_BITS-1:0] rx_data;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_valid = 0;
    int n_err = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_core #(.DATA_BITS(DATA_BITS), .STOP_TICKS(STOP_TICKS), .CLK_DIV(CLK_DIV)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_rx       (rx_line),
        .i_tx_start (tx_start),
        .i_tx_data  (tx_data),
        .o_tx       (tx),
        .o_tx_busy  (tx_busy),
        .o_tx_done  (tx_done),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_rx_err   (rx_err)
    );

    always @(posedge clk) begin
        if (tx_done) n_done++;
        if (rx_valid) n_valid++;
        if (rx_err) n_err++;
    end

    function automatic logic [NBITS-1:0] build_frame(input logic [DATA_BITS-1:0] d);
        logic [NBITS-1:0] f;
        f = '0;
        for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
        if (P == 1) f[1+DATA_BITS] = ^d;
        f[NBITS-1] = 1'b1;
        return f;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the caller one negedge after the accepting edge (frame offset 0).
    task automatic send(input logic [DATA_BITS-1:0] d);
        tx_data = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic drive_frame(input logic [DATA_BITS-1:0] d, input logic par, input int stop_low);
        rx_drv = 1'b0;
        cycles(BIT_CYC);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx_drv = d[i];
            cycles(BIT_CYC);
        end
        if (P == 1) begin
            rx_drv = par;
            cycles(BIT_CYC);
        end
        if (stop_low > 0) begin
            rx_drv = 1'b0;
            cycles(stop_low);
        end
        rx_drv = 1'b1;
        cycles(200);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(3);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        total++; if (rx_valid !== 1'b0 || rx_err !== 1'b0) begin
            bad++; $display("FAIL reset_rx_pulses: got valid=%b err=%b want 0 0", rx_valid, rx_err);
        end
        reset = 1'b0;
        cycles(5);
        total++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: got tx=%b busy=%b want 1 0", tx, tx_busy);
        end
    endtask

    task automatic test_transmit(input logic [DATA_BITS-1:0] d);
        logic [NBITS-1:0] f;
        int cur, tgt, base;
        bit ok;
        f = build_frame(d);
        loop_en = 1'b0;
        base = n_done;
        send(d);
        total++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            bad++; $display("FAIL tx_first_cycle: got tx=%b busy=%b want 0 1", tx, tx_busy);
        end
        cur = 0;
        for (int j = 0; j < NBITS; j++) begin
            tgt = BIT_CYC / 2 + BIT_CYC * j;
            cycles(tgt - cur);
            cur = tgt;
            total++; if (tx !== f[j]) begin bad++; $display("FAIL tx_bit%0d data=%h: got %b want %b", j, d, tx, f[j]); end
            total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL tx_busy_bit%0d: got %b want 1", j, tx_busy); end
        end
        wait_done(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL tx_done_timeout: got no done want done"); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL busy_with_done: got %b want 0", tx_busy); end
        cycles(10);
        total++; if (n_done - base !== 1) begin bad++; $display("FAIL tx_done_count: got %0d want 1", n_done - base); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL tx_idle_after: got %b want 1", tx); end
    endtask

    task automatic test_loopback();
        int bv, be;
        bit ok;
        loop_en = 1'b1;
        bv = n_valid; be = n_err;
        send(8'h3C);
        wait_done(800, ok);
        total++; if (!ok) begin bad++; $display("FAIL loop_done_timeout: got no done want done"); end
        cycles(50);
        total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL loop_valid_count: got %0d want 1", n_valid - bv); end
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL loop_rx_data: got %h want 3c", rx_data); end
        total++; if (n_err - be !== 0) begin bad++; $display("FAIL loop_err_count: got %0d want 0", n_err - be); end
        loop_en = 1'b0;
    endtask

    task automatic test_framing();
        int bv, be;
        loop_en = 1'b0;
        bv = n_valid; be = n_err;
        drive_frame(8'h55, 1'b0, 48);
        total++; if (n_err - be !== 1) begin bad++; $display("FAIL frame_err_count: got %0d want 1", n_err - be); end
        total++; if (n_valid - bv !== 0) begin bad++; $display("FAIL frame_valid_count: got %0d want 0", n_valid - bv); end
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL frame_rx_hold: got %h want 3c", rx_data); end
    endtask

    task automatic test_glitch();
        int bv, be;
        loop_en = 1'b0;
        bv = n_valid; be = n_err;
        rx_drv = 1'b0;
        cycles(20);
        rx_drv = 1'b1;
        cycles(150);
        total++; if (n_valid - bv !== 0 || n_err - be !== 0) begin
            bad++; $display("FAIL glitch_pulses: got valid=%0d err=%0d want 0 0", n_valid - bv, n_err - be);
        end
    endtask

    task automatic test_busy_drop();
        int bd, bv;
        bit ok;
        loop_en = 1'b1;
        bd = n_done; bv = n_valid;
        send(8'h5A);
        cycles(200);
        tx_data = 8'hFF;
        tx_start = 1'b1;
        cycles(1);
        tx_start = 1'b0;
        wait_done(800, ok);
        total++; if (!ok) begin bad++; $display("FAIL busy_done_timeout: got no done want done"); end
        cycles(300);
        total++; if (n_done - bd !== 1) begin bad++; $display("FAIL busy_frame_count: got %0d want 1", n_done - bd); end
        total++; if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            bad++; $display("FAIL busy_idle_after: got busy=%b tx=%b want 0 1", tx_busy, tx);
        end
        total++; if (n_valid - bv !== 1 || rx_data !== 8'h5A) begin
            bad++; $display("FAIL busy_rx: got count=%0d data=%h want 1 5a", n_valid - bv, rx_data);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bv, be;
        bit ok;
        loop_en = 1'b1;
        bv = n_valid; be = n_err;
        send(8'h96);
        wait_done(800, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout: got no done want done"); end
        tx_data = 8'h69;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        total++; if (tx_busy !== 1'b1 || tx !== 1'b0) begin
            bad++; $display("FAIL b2b_accept: got busy=%b tx=%b want 1 0", tx_busy, tx);
        end
        wait_done(800, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_second_timeout: got no done want done"); end
        cycles(50);
        total++; if (n_valid - bv !== 2 || n_err - be !== 0) begin
            bad++; $display("FAIL b2b_rx_counts: got valid=%0d err=%0d want 2 0", n_valid - bv, n_err - be);
        end
        total++; if (rx_data !== 8'h69) begin bad++; $display("FAIL b2b_rx_data: got %h want 69", rx_data); end
        loop_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int bd, bv, be;
        loop_en = 1'b1;
        bd = n_done; bv = n_valid; be = n_err;
        send(8'hFF);
        cycles(199);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_out: got tx=%b busy=%b want 1 0", tx, tx_busy);
        end
        cycles(800);
        total++; if (n_done - bd !== 0) begin bad++; $display("FAIL rst_mid_done: got %0d want 0", n_done - bd); end
        total++; if (n_valid - bv !== 0 || n_err - be !== 0) begin
            bad++; $display("FAIL rst_mid_rx: got valid=%0d err=%0d want 0 0", n_valid - bv, n_err - be);
        end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_rx_data: got %h want 00", rx_data); end
        loop_en = 1'b0;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int bv, be;
        bit ok;
        loop_en = 1'b0;
        send(8'h07);
        cycles(BIT_CYC / 2 + BIT_CYC * 9);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL par_tx_bit: got %b want 1", tx); end
        wait_done(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL par_done_timeout: got no done want done"); end
        bv = n_valid; be = n_err;
        drive_frame(8'h07, 1'b1, 0);
        total++; if (n_valid - bv !== 1 || rx_data !== 8'h07) begin
            bad++; $display("FAIL par_good_rx: got count=%0d data=%h want 1 07", n_valid - bv, rx_data);
        end
        bv = n_valid; be = n_err;
        drive_frame(8'h07, 1'b0, 0);
        total++; if (n_err - be !== 1 || n_valid - bv !== 0) begin
            bad++; $display("FAIL par_bad_rx: got err=%0d valid=%0d want 1 0", n_err - be, n_valid - bv);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_transmit(8'hA5);
        test_transmit(8'h01);
        test_loopback();
        test_framing();
        test_glitch();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
